// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//   Shared types and constants for the PWM generator / capture pair.
//   - PWM_WIDTH       : default counter width used by both sides
//   - pwm_cap_state_t : capture FSM state encoding
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_cap_state_t;

endpackage : pwm_pkg

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//   Multi-flop synchronizer for an asynchronous level, followed by one extra
//   flop for single-cycle edge detection on the synchronized signal.
//   Parameters:
//     STAGES : synchronizer depth (must be >= 2)
//   Ports:
//     CLK, RST : clock, asynchronous active-high reset
//     d        : asynchronous input level
//     q        : synchronized level
//     rise     : one-cycle pulse on a synchronized 0->1 transition
//     fall     : one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise =  q & ~prev_q;
  assign fall = ~q &  prev_q;

endmodule : sync_edge_det

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//   Measures period and high time of an asynchronous PWM input.
//   Parameters:
//     WIDTH       : counter / result width
//     SYNC_STAGES : input synchronizer depth (>= 2)
//   Ports:
//     CLK, RST : system clock, asynchronous active-high reset
//     PWM_IN   : asynchronous PWM waveform
//     Period   : rising-edge to rising-edge cycle count (0 after a timeout)
//     HighTime : cycles high within that period (all-ones/0 after a timeout,
//                following the stuck level)
//     Valid    : one-cycle strobe, Period/HighTime update in the same cycle
//     Stuck    : input stopped toggling; cleared by the next measurement
// ---------------------------------------------------------------------------
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWM_IN,
  output logic [WIDTH-1:0] Period,
  output logic [WIDTH-1:0] HighTime,
  output logic             Valid,
  output logic             Stuck
);

  logic sync_lvl, rise, fall;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .d    (PWM_IN),
    .q    (sync_lvl),
    .rise (rise),
    .fall (fall)
  );

  pwm_cap_state_t   state_q, state_d;
  logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             timeout;

  // The period counter saturating means the input has stopped toggling. A rise
  // in the same cycle wins, so a period of exactly 2^WIDTH-1 is still reported,
  // and the counter can never wrap.
  assign timeout = (per_cnt_q == '1) && !rise;

  // NOTE: every signal gets a default at the top of the block so no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;

    unique case (state_q)
      IDLE: begin
        // First rise only opens a measurement; nothing is published.
        if (rise) begin
          state_d   = HIGH;
          per_cnt_d = WIDTH'(1);
          hi_cnt_d  = WIDTH'(1);
        end
      end

      HIGH: begin
        if (timeout) begin
          state_d     = IDLE;
          period_d    = '0;
          high_time_d = sync_lvl ? '1 : '0;
          valid_d     = 1'b1;
          stuck_d     = 1'b1;
        end else if (fall) begin
          state_d   = LOW;
          per_cnt_d = per_cnt_q + WIDTH'(1);
        end else begin
          per_cnt_d = per_cnt_q + WIDTH'(1);
          hi_cnt_d  = hi_cnt_q + WIDTH'(1);
        end
      end

      LOW: begin
        if (rise) begin
          state_d     = HIGH;
          period_d    = per_cnt_q;
          high_time_d = hi_cnt_q;
          valid_d     = 1'b1;
          stuck_d     = 1'b0;
          per_cnt_d   = WIDTH'(1);
          hi_cnt_d    = WIDTH'(1);
        end else if (timeout) begin
          state_d     = IDLE;
          period_d    = '0;
          high_time_d = sync_lvl ? '1 : '0;
          valid_d     = 1'b1;
          stuck_d     = 1'b1;
        end else begin
          per_cnt_d = per_cnt_q + WIDTH'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
    end
  end

  assign Period   = period_q;
  assign HighTime = high_time_q;
  assign Valid    = valid_q;
  assign Stuck    = stuck_q;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//   Directed bench for pwm_capture: a WIDTH=16 instance for the period/duty
//   cases and a WIDTH=8 instance for timeout, boundary and reset cases.
//   Strobes are logged per instance and compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

  typedef struct {
    int p;
    int h;
    int s;
    int c;
  } strobe_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm16 = 1'b0;
  logic        pwm8  = 1'b0;
  logic [15:0] period16, high16;
  logic        valid16, stuck16;
  logic [7:0]  period8, high8;
  logic        valid8, stuck8;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  strobe_t log16[$];
  strobe_t log8[$];

  always #10 clk = ~clk;

  pwm_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .CLK      (clk),
    .RST      (rst),
    .PWM_IN   (pwm16),
    .Period   (period16),
    .HighTime (high16),
    .Valid    (valid16),
    .Stuck    (stuck16)
  );

  pwm_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .CLK      (clk),
    .RST      (rst),
    .PWM_IN   (pwm8),
    .Period   (period8),
    .HighTime (high8),
    .Valid    (valid8),
    .Stuck    (stuck8)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid16 === 1'b1) log16.push_back('{int'(period16), int'(high16), int'(stuck16), cyc});
    if (valid8  === 1'b1) log8.push_back('{int'(period8), int'(high8), int'(stuck8), cyc});
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic strobe_t get16(input int i);
    strobe_t z = '{0, 0, 0, 0};
    return (i >= 0 && i < log16.size()) ? log16[i] : z;
  endfunction

  function automatic strobe_t get8(input int i);
    strobe_t z = '{0, 0, 0, 0};
    return (i >= 0 && i < log8.size()) ? log8[i] : z;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    pwm16 = 1'b0;
    pwm8  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    log16.delete();
    log8.delete();
    repeat (3) @(negedge clk);
  endtask

  // n periods of 'hi' cycles high then 'per-hi' low; each period starts with a rise.
  task automatic gen16(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        pwm16 = (c < hi);
      end
  endtask

  task automatic gen8(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        pwm8 = (c < hi);
      end
  endtask

  task automatic close16();
    @(negedge clk);
    pwm16 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic close8();
    @(negedge clk);
    pwm8 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    strobe_t e;
    int      n;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_period16", period16, 0);
    check("rst_high16",   high16,   0);
    check("rst_valid16",  valid16,  0);
    check("rst_stuck16",  stuck16,  0);
    check("rst_period8",  period8,  0);
    check("rst_valid8",   valid8,   0);

    // Period 100, high 25: five rises plus closing rise -> five strobes
    do_reset();
    gen16(100, 25, 5);
    close16();
    check("pd_count", log16.size(), 5);
    e = get16(4);
    check("pd_period", e.p, 100);
    check("pd_high",   e.h, 25);
    check("pd_stuck",  e.s, 0);
    check("pd_interval", get16(4).c - get16(3).c, 100);
    check("pd_hold_period", period16, 100);

    // Narrow pulse 7/1 then 6/7
    do_reset();
    gen16(7, 1, 4);
    gen16(7, 6, 3);
    close16();
    check("nar_count", log16.size(), 7);
    check("nar_p0", get16(0).p, 7);
    check("nar_h0", get16(0).h, 1);
    check("nar_h3", get16(3).h, 1);
    check("nar_h4", get16(4).h, 6);
    check("nar_p4", get16(4).p, 7);

    // Stuck high on WIDTH=8
    do_reset();
    gen8(10, 4, 2);
    close8();
    repeat (260) @(negedge clk);
    check("sh_count", log8.size(), 3);
    e = get8(2);
    check("sh_period", e.p, 0);
    check("sh_high",   e.h, 255);
    check("sh_stuck",  e.s, 1);
    check("sh_interval", get8(2).c - get8(1).c, 255);
    repeat (300) @(negedge clk);
    check("sh_no_repeat", log8.size(), 3);
    check("sh_stuck_out", stuck8, 1);
    @(negedge clk);
    pwm8 = 1'b0;
    repeat (5) @(negedge clk);
    gen8(10, 4, 3);
    close8();
    check("sh_recover_count", log8.size(), 6);
    e = get8(5);
    check("sh_rec_period", e.p, 10);
    check("sh_rec_high",   e.h, 4);
    check("sh_rec_stuck",  e.s, 0);
    check("sh_rec_stuck_out", stuck8, 0);

    // Stuck low on WIDTH=8
    do_reset();
    gen8(10, 4, 2);
    repeat (270) @(negedge clk);
    check("sl_count", log8.size(), 2);
    e = get8(1);
    check("sl_period", e.p, 0);
    check("sl_high",   e.h, 0);
    check("sl_stuck",  e.s, 1);
    check("sl_interval", get8(1).c - get8(0).c, 255);
    repeat (1000) @(negedge clk);
    check("sl_no_repeat", log8.size(), 2);

    // Boundary: period exactly 255
    do_reset();
    gen8(255, 100, 3);
    close8();
    check("bd_count", log8.size(), 3);
    n = log8.size() - 1;
    e = get8(n);
    check("bd_period", e.p, 255);
    check("bd_high",   e.h, 100);
    check("bd_stuck",  e.s, 0);

    // Reset in the middle of a high phase
    do_reset();
    gen8(20, 8, 2);
    @(negedge clk);
    pwm8 = 1'b1;
    repeat (4) @(negedge clk);
    check("mr_pre_period", period8, 20);
    #3;
    rst = 1'b1;
    #1;
    check("mr_period", period8, 0);
    check("mr_high",   high8,   0);
    check("mr_valid",  valid8,  0);
    check("mr_stuck",  stuck8,  0);
    @(negedge clk);
    pwm8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    log8.delete();
    repeat (3) @(negedge clk);
    gen8(20, 8, 3);
    close8();
    check("mr_count", log8.size(), 3);
    check("mr_p0", get8(0).p, 20);
    check("mr_h0", get8(0).h, 8);
    check("mr_interval", get8(1).c - get8(0).c, 20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pwm_capture
